// File: rtl/reset_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// No logic of its own.
package reset_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_state_e;

    function automatic int cnt_width(input int stretch, input int gap);
        int longest;
        longest = (stretch > gap) ? stretch : gap;
        return $clog2(longest + 1);
    endfunction

    function automatic int idx_width(input int num_out);
        return (num_out > 1) ? $clog2(num_out) : 1;
    endfunction

endpackage

// File: rtl/reset_sync_bit_chain.sv
// Single-bit synchronizer chain for an asynchronous level into clk.
// Latency: STAGES clk edges; cleared to 0 by the synchronous reset.
module sync_bit_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Reset controller: merges async requests, stretches reset, releases outputs in index order.
// Latency: request to all outputs low is SYNC_STAGES+1 edges; release spaced by RELEASE_GAP.
module reset_seq
    import reset_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int NUM_OUT        = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int RELEASE_GAP    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] rst_req_i,
    input  logic [NUM_SRC-1:0] src_mask_i,
    input  logic               cause_clr_i,
    output logic [NUM_OUT-1:0] rst_out_n_o,
    output logic               all_released_o,
    output logic               busy_o,
    output logic [NUM_SRC-1:0] rst_cause_o
);

    localparam int CNT_W = cnt_width(STRETCH_CYCLES, RELEASE_GAP);
    localparam int IDX_W = idx_width(NUM_OUT);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    logic [NUM_SRC-1:0] sync_out;
    logic [NUM_SRC-1:0] req_vec;
    logic               req_s;

    rst_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] rst_out_n_q, rst_out_n_d;
    logic [NUM_SRC-1:0] cause_q, cause_d;
    logic               last_step;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        sync_bit_chain #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d_i  (rst_req_i[g]),
            .q_o  (sync_out[g])
        );
    end

    // Masking applies after synchronization so a mask change acts on the next edge.
    assign req_vec   = sync_out & ~src_mask_i;
    assign req_s     = |req_vec;
    assign last_step = (int'(idx_q) == NUM_OUT - 2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HOLD: begin
                if (!req_s && cnt_q == STRETCH_LAST) begin
                    state_d = (NUM_OUT == 1) ? RUN : RELEASE;
                end
            end
            RELEASE: begin
                if (req_s) begin
                    state_d = HOLD;
                end else if (cnt_q == GAP_LAST && last_step) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (req_s) begin
                    state_d = HOLD;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rst_out_n_d = rst_out_n_q;
        if (req_s) begin
            cnt_d       = '0;
            idx_d       = '0;
            rst_out_n_d = '0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == STRETCH_LAST) begin
                        rst_out_n_d[0] = 1'b1;
                        cnt_d          = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (i == int'(idx_q) + 1) begin
                                rst_out_n_d[i] = 1'b1;
                            end
                        end
                        idx_d = idx_q + 1'b1;
                        cnt_d = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A set on the same edge as a clear wins for the bits being set.
    always_comb begin
        cause_d = (cause_clr_i ? '0 : cause_q) | req_vec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_out_n_q <= '0;
            cause_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rst_out_n_q <= rst_out_n_d;
            cause_q     <= cause_d;
        end
    end

    assign rst_out_n_o    = rst_out_n_q;
    assign all_released_o = &rst_out_n_q;
    assign busy_o         = (state_q != RUN);
    assign rst_cause_o    = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: default config and a minimal config driven by shared random/directed stimulus.
// Reference tracks quiet-edge count since the last merged request; output i is high once it reaches S + i*G.
module tb_reset_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] mask;
    logic       clr;

    logic [2:0] a_out;
    logic       a_all, a_busy;
    logic [3:0] a_cause;
    logic [0:0] b_out;
    logic       b_all, b_busy;
    logic [3:0] b_cause;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reset_seq #(
        .NUM_SRC(4), .NUM_OUT(3), .SYNC_STAGES(2), .STRETCH_CYCLES(16), .RELEASE_GAP(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .rst_req_i(req), .src_mask_i(mask), .cause_clr_i(clr),
        .rst_out_n_o(a_out), .all_released_o(a_all), .busy_o(a_busy), .rst_cause_o(a_cause)
    );

    reset_seq #(
        .NUM_SRC(4), .NUM_OUT(1), .SYNC_STAGES(3), .STRETCH_CYCLES(1), .RELEASE_GAP(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .rst_req_i(req), .src_mask_i(mask), .cause_clr_i(clr),
        .rst_out_n_o(b_out), .all_released_o(b_all), .busy_o(b_busy), .rst_cause_o(b_cause)
    );

    typedef struct packed {
        logic [7:0][3:0] hist;
        logic [3:0]      cause;
        logic [15:0]     quiet;
    } mdl_t;

    mdl_t ma = '0;
    mdl_t mb = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // hist[k] holds the request vector sampled k+1 edges ago; ss edges of delay reach the merge.
    function automatic mdl_t mdl_step(input mdl_t m, input int ss, input logic rst,
                                      input logic [3:0] r, input logic [3:0] mk, input logic c);
        mdl_t n;
        logic [3:0] seen;
        n = m;
        if (!rst) begin
            n = '0;
        end else begin
            seen    = m.hist[ss-1] & ~mk;
            n.cause = (c ? 4'b0000 : m.cause) | seen;
            if (|seen)
                n.quiet = '0;
            else if (m.quiet != 16'hffff)
                n.quiet = m.quiet + 16'd1;
            n.hist = {m.hist[6:0], r};
        end
        return n;
    endfunction

    function automatic int exp_out(input int quiet, input int s, input int g, input int n);
        int v;
        v = 0;
        for (int i = 0; i < n; i++)
            if (quiet >= s + i * g) v |= (1 << i);
        return v;
    endfunction

    task automatic tick();
        int ea, eb;
        @(posedge clk);
        ma = mdl_step(ma, 2, rst_n, req, mask, clr);
        mb = mdl_step(mb, 3, rst_n, req, mask, clr);
        #1;
        ea = exp_out(int'(ma.quiet), 16, 8, 3);
        eb = exp_out(int'(mb.quiet), 1, 1, 1);
        chk("a_out",   32'(a_out),   32'(ea));
        chk("a_all",   32'(a_all),   32'(ea == 7));
        chk("a_busy",  32'(a_busy),  32'(ea != 7));
        chk("a_cause", 32'(a_cause), 32'(ma.cause));
        chk("b_out",   32'(b_out),   32'(eb));
        chk("b_all",   32'(b_all),   32'(eb == 1));
        chk("b_busy",  32'(b_busy),  32'(eb != 1));
        chk("b_cause", 32'(b_cause), 32'(mb.cause));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        mask  = '0;
        clr   = 1'b0;

        // Power-on
        ticks(5);
        chk("por_busy", 32'(a_busy), 32'd1);
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 1)  chk("por_b_out1", 32'(b_out), 32'd1);
            if (k == 15) chk("por_out15", 32'(a_out), 32'd0);
            if (k == 16) chk("por_out16", 32'(a_out), 32'd1);
            if (k == 23) chk("por_out23", 32'(a_out), 32'd1);
            if (k == 24) chk("por_out24", 32'(a_out), 32'd3);
            if (k == 31) chk("por_all31", 32'(a_all), 32'd0);
            if (k == 32) begin
                chk("por_out32", 32'(a_out), 32'd7);
                chk("por_all32", 32'(a_all), 32'd1);
                chk("por_busy32", 32'(a_busy), 32'd0);
            end
        end

        // Request pulse on src1 while running
        req = 4'b0010;
        ticks(2);
        tick();
        chk("pulse_a_out3", 32'(a_out), 32'd0);
        chk("pulse_b_out3", 32'(b_out), 32'd1);
        chk("pulse_cause", 32'(a_cause), 32'h2);
        req = '0;
        tick();
        chk("pulse_b_out4", 32'(b_out), 32'd0);
        ticks(40);

        // Held request
        req = 4'b0001;
        ticks(100);
        req = '0;
        ticks(40);

        // Mid-release abort
        req = 4'b0100;
        ticks(2);
        req = '0;
        ticks(20);
        chk("abort_pre", 32'(a_out), 32'd1);
        req = 4'b0100;
        ticks(3);
        chk("abort_post", 32'(a_out), 32'd0);
        chk("abort_cause2", 32'(a_cause[2]), 32'd1);
        req = '0;
        ticks(40);

        // Masked source
        clr = 1'b1;
        tick();
        clr = 1'b0;
        mask = 4'b1000;
        req  = 4'b1000;
        ticks(3);
        req = '0;
        ticks(5);
        chk("mask_out", 32'(a_out), 32'd7);
        chk("mask_cause", 32'(a_cause), 32'd0);
        mask = '0;
        ticks(3);

        // Clear colliding with a set
        req = 4'b0001;
        ticks(2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("collide_cause", 32'(a_cause), 32'd1);
        req = '0;
        ticks(45);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clear_cause", 32'(a_cause), 32'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (req[b]) begin
                    if ($urandom_range(0, 7) == 0) req[b] = 1'b0;
                end else begin
                    if ($urandom_range(0, 149) == 0) req[b] = 1'b1;
                end
            end
            if ($urandom_range(0, 199) == 0) mask = 4'($urandom_range(0, 15));
            clr   = ($urandom_range(0, 24) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
Parametrised reset controller and sequencer in the clk domain.
- Merges NUM_SRC asynchronous reset-request sources through per-bit synchronizer chains.
- Stretches the resulting reset to a minimum width.
- Releases NUM_OUT downstream reset outputs in a fixed order with a programmable gap between releases.
- Records a sticky reset cause for software.
- Successor to the two-flop reset synchronizers; sits at the top of each subsystem's reset tree.

Parameters:
NUM_SRC, 4, number of async reset-request inputs (>=1)
NUM_OUT, 3, number of sequenced reset outputs (>=1)
SYNC_STAGES, 2, synchronizer flops per request bit (>=2)
STRETCH_CYCLES, 16, minimum clk cycles reset is held after the last request drops (>=1)
RELEASE_GAP, 8, clk cycles between successive output releases (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
rst_req_i  in  NUM_SRC  async reset requests, active-high, level
src_mask_i  in  NUM_SRC  quasi-static; 1 = source ignored
cause_clr_i  in  1  single-cycle pulse, clears rst_cause_o
rst_out_n_o  out  NUM_OUT  sequenced resets, active-low, registered
all_released_o  out  1  1 when every rst_out_n_o bit is high
busy_o  out  1  1 in HOLD or RELEASE
rst_cause_o  out  NUM_SRC  sticky record of unmasked sources that fired

Behaviour:
- rst_n=0, sampled on clk:
  - sync flops = 0; rst_out_n_o = 0; all_released_o = 0; busy_o = 1; rst_cause_o = 0.
  - State = HOLD, counter = 0, release index = 0.
- Synchronizer: each rst_req_i bit passes through SYNC_STAGES flops marked ASYNC_REG. req_s = OR(sync_out & ~src_mask_i).
- Request latency: async rise → rst_out_n_o all 0 in exactly SYNC_STAGES+1 clk edges, from any state.
- FSM states: HOLD, RELEASE, RUN.
  - HOLD:
    - req_s=1 forces counter to 0.
    - Otherwise counter increments.
    - When counter = STRETCH_CYCLES-1 and req_s=0: next edge goes to RELEASE, sets rst_out_n_o[0]=1, clears counter.
    - Net effect: out[0] rises STRETCH_CYCLES edges after the first edge with req_s=0 (or with rst_n=1 after reset).
  - RELEASE:
    - Counter counts up to RELEASE_GAP-1. The next edge sets rst_out_n_o[idx+1]=1, increments idx and clears the counter.
    - When the last output is released, the same edge enters RUN and sets all_released_o=1.
    - If NUM_OUT=1, HOLD goes straight to RUN; all_released_o rises with out[0].
  - RUN: busy_o=0; outputs held high.
  - Any state with req_s=1: next edge sets all rst_out_n_o=0, all_released_o=0, state HOLD, counter 0, idx 0. This covers mid-release and mid-stretch; the sequence restarts from scratch.
- Release order is strictly index 0 → NUM_OUT-1. Assertion is simultaneous for all outputs.
- rst_cause_o: each edge ORs in (sync_out & ~src_mask_i). cause_clr_i clears it. If clear and set occur on the same edge, set wins for the bits being set.
- Counter width: $clog2(max(STRETCH_CYCLES, RELEASE_GAP)+1). Counter saturates; it never wraps.
- A mask change takes effect after one edge. Masking an active source behaves as its request dropping.
- Glitches shorter than one clk period may be missed; this is acceptable.

Decomposition:
- Package reset_pkg: state enum rst_state_e {HOLD, RELEASE, RUN}; helper function for the counter width.
- Sub-module sync_bit_chain (parameter STAGES, 1-bit, reset to 0 by rst_n), instantiated NUM_SRC times.
- The FSM, counters and cause register live in reset_seq.

Test Plan (defaults unless stated):
- Power-on: rst_n low 5 cycles, then high, no requests → out[0] rises at edge 16, out[1] at 24, out[2] at 32; all_released_o=1 at edge 32; busy_o=0 from edge 32; rst_cause_o=0.
- In RUN, pulse rst_req_i[1] for 3 cycles → all outputs 0 at edge 3 after the rise; rst_cause_o=4'b0010. Out[0] rises 16 edges after synchronized req drops; full sequence then completes.
- Held request: rst_req_i[0] high 100 cycles → outputs stay 0 and busy_o=1 throughout; out[0] rises 16 edges after the sync output falls.
- Mid-release abort: request on src2 when out[0]=1 and out[1]=0 → all outputs 0 after 3 edges; restart gives out[0] 16 edges after drop; rst_cause_o[2]=1.
- Mask: src_mask_i=4'b1000, pulse rst_req_i[3] → no output change; rst_cause_o stays 0.
- Cause clear collision: cause_clr_i on the same edge src0's sync output rises → rst_cause_o=4'b0001. A clear alone on the next pulse → 0.
- Param sweep: NUM_OUT=1, SYNC_STAGES=3, STRETCH_CYCLES=1, RELEASE_GAP=1 → request latency 4 edges; out[0] and all_released_o rise 1 edge after the request drops.
